// File: rtl/axi_lite_reg_dispatch_pkg.sv
// rtl/axi_lite_reg_dispatch_pkg.sv - shared constants for the register dispatcher
//
// Purpose: FSM state encodings and a width helper used by axi_lite_reg_dispatch.
// Ports:   none (package).

package axi_lite_reg_dispatch_pkg;

  // 3-bit state encodings, kept as plain constants for compatibility with older tooling.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_WAIT = 3'd1;
  localparam logic [2:0] ST_RD_WAIT = 3'd2;
  localparam logic [2:0] ST_RESPOND = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  // $clog2 that never returns 0, so single-entry ranges still get a 1-bit field.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axi_lite_reg_dispatch.sv
// rtl/axi_lite_reg_dispatch.sv - routes the AXI-Lite slave register interface onto NUM_DEVS banks
//
// Purpose: accepts one upstream register read/write at a time, decodes the bank index from
//          the upper address bits, strobes the selected bank for one cycle and waits for its
//          ack (bounded by TIMEOUT_CYCLES). Out-of-range or timed-out accesses complete with
//          o_reg_invalid_addr=1 so the slave can answer DECERR.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   i_reg_in_rdy / o_reg_in_ack_stb     upstream write request level / completion pulse
//   i_reg_out_req / o_reg_out_rdy_stb   upstream read request level / data-valid pulse
//   i_reg_address, i_reg_in_data        upstream address and write data
//   o_reg_out_data, o_reg_invalid_addr  read data and DECERR flag, held until next response
//   o_dev_wr_stb, o_dev_rd_stb          one-hot per-bank strobes, 1-cycle pulses
//   o_dev_address, o_dev_wdata          bank-local offset and write data
//   i_dev_ack, i_dev_rdata              per-bank ack pulses and flattened read data
//   o_busy                              high whenever not idle

module axi_lite_reg_dispatch
  import axi_lite_reg_dispatch_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_DEVS       = 4,
  parameter int DEV_ADDR_BITS  = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_reg_in_rdy,
  output logic                           o_reg_in_ack_stb,
  input  logic [ADDR_WIDTH-1:0]          i_reg_address,
  input  logic [DATA_WIDTH-1:0]          i_reg_in_data,
  input  logic                           i_reg_out_req,
  output logic                           o_reg_out_rdy_stb,
  output logic [DATA_WIDTH-1:0]          o_reg_out_data,
  output logic                           o_reg_invalid_addr,
  output logic [NUM_DEVS-1:0]            o_dev_wr_stb,
  output logic [NUM_DEVS-1:0]            o_dev_rd_stb,
  output logic [DEV_ADDR_BITS-1:0]       o_dev_address,
  output logic [DATA_WIDTH-1:0]          o_dev_wdata,
  input  logic [NUM_DEVS-1:0]            i_dev_ack,
  input  logic [NUM_DEVS*DATA_WIDTH-1:0] i_dev_rdata,
  output logic                           o_busy
);

  localparam int IDX_W = clog2_min1(NUM_DEVS);
  localparam int CNT_W = clog2_min1(TIMEOUT_CYCLES + 1);
  localparam int HI_W  = ADDR_WIDTH - DEV_ADDR_BITS;

  logic [2:0]               state_q,      state_d;
  logic [IDX_W-1:0]         idx_q,        idx_d;
  logic [CNT_W-1:0]         cnt_q,        cnt_d;
  logic [NUM_DEVS-1:0]      wr_stb_q,     wr_stb_d;
  logic [NUM_DEVS-1:0]      rd_stb_q,     rd_stb_d;
  logic [DEV_ADDR_BITS-1:0] dev_addr_q,   dev_addr_d;
  logic [DATA_WIDTH-1:0]    dev_wdata_q,  dev_wdata_d;
  logic                     in_ack_q,     in_ack_d;
  logic                     out_rdy_q,    out_rdy_d;
  logic [DATA_WIDTH-1:0]    out_data_q,   out_data_d;
  logic                     invalid_q,    invalid_d;

  logic [HI_W-1:0]          req_idx;
  logic                     req_idx_ok;
  logic [NUM_DEVS-1:0]      req_onehot;
  logic                     sel_ack;
  logic [CNT_W-1:0]         cnt_inc;
  logic                     expire;
  logic [DATA_WIDTH-1:0]    rdata_sel;

  assign req_idx    = i_reg_address[ADDR_WIDTH-1:DEV_ADDR_BITS];
  assign req_idx_ok = (32'(req_idx) < NUM_DEVS);
  assign sel_ack    = i_dev_ack[idx_q];
  assign rdata_sel  = i_dev_rdata[idx_q*DATA_WIDTH +: DATA_WIDTH];
  assign cnt_inc    = cnt_q + CNT_W'(1);
  // Expiry is judged on the incremented value, so an ack on that same cycle still wins.
  assign expire     = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    req_onehot = '0;
    for (int i = 0; i < NUM_DEVS; i++) begin
      req_onehot[i] = (32'(req_idx) == i);
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    wr_stb_d    = '0;
    rd_stb_d    = '0;
    dev_addr_d  = dev_addr_q;
    dev_wdata_d = dev_wdata_q;
    in_ack_d    = 1'b0;
    out_rdy_d   = 1'b0;
    out_data_d  = out_data_q;
    invalid_d   = invalid_q;

    case (state_q)
      ST_IDLE: begin
        if (i_reg_in_rdy || i_reg_out_req) begin
          idx_d       = req_idx[IDX_W-1:0];
          dev_addr_d  = i_reg_address[DEV_ADDR_BITS-1:0];
          dev_wdata_d = i_reg_in_data;
          cnt_d       = '0;
          if (!req_idx_ok) begin
            // No bank behind this index: answer straight away with DECERR.
            invalid_d = 1'b1;
            state_d   = ST_RESPOND;
            if (i_reg_in_rdy) begin
              in_ack_d = 1'b1;
            end else begin
              out_rdy_d  = 1'b1;
              out_data_d = '0;
            end
          end else if (i_reg_in_rdy) begin
            wr_stb_d = req_onehot;
            state_d  = ST_WR_WAIT;
          end else begin
            rd_stb_d = req_onehot;
            state_d  = ST_RD_WAIT;
          end
        end
      end

      ST_WR_WAIT, ST_RD_WAIT: begin
        if (sel_ack || expire) begin
          invalid_d = !sel_ack;
          state_d   = ST_RESPOND;
          if (state_q == ST_WR_WAIT) begin
            in_ack_d = 1'b1;
          end else begin
            out_rdy_d  = 1'b1;
            out_data_d = sel_ack ? rdata_sel : '0;
          end
        end
        // Counter saturates at the expiry value; it stays parked while the timeout is disabled.
        if (!sel_ack && (TIMEOUT_CYCLES != 0)) begin
          cnt_d = cnt_inc;
        end
      end

      ST_RESPOND: begin
        state_d = ST_RELEASE;
      end

      ST_RELEASE: begin
        // The slave keeps its request high through its own response phase; wait it out.
        if (!i_reg_in_rdy && !i_reg_out_req) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      wr_stb_q    <= '0;
      rd_stb_q    <= '0;
      dev_addr_q  <= '0;
      dev_wdata_q <= '0;
      in_ack_q    <= 1'b0;
      out_rdy_q   <= 1'b0;
      out_data_q  <= '0;
      invalid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      wr_stb_q    <= wr_stb_d;
      rd_stb_q    <= rd_stb_d;
      dev_addr_q  <= dev_addr_d;
      dev_wdata_q <= dev_wdata_d;
      in_ack_q    <= in_ack_d;
      out_rdy_q   <= out_rdy_d;
      out_data_q  <= out_data_d;
      invalid_q   <= invalid_d;
    end
  end

  assign o_reg_in_ack_stb   = in_ack_q;
  assign o_reg_out_rdy_stb  = out_rdy_q;
  assign o_reg_out_data     = out_data_q;
  assign o_reg_invalid_addr = invalid_q;
  assign o_dev_wr_stb       = wr_stb_q;
  assign o_dev_rd_stb       = rd_stb_q;
  assign o_dev_address      = dev_addr_q;
  assign o_dev_wdata        = dev_wdata_q;
  assign o_busy             = (state_q != ST_IDLE);

endmodule
